// File: rtl/bus_dma.sv
// bus_dma: single-channel word DMA (copy, or fill when BUS_DMA_FILL_EN is defined) on a strobe/ack bus
module bus_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [31:0]      adr_o,
  output logic [3:0]       sel_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);
  typedef enum logic [2:0] {IDLE, RD, RDCAP, WR, FIN} state_t;
  state_t state, next;
  logic [31:0] src, dst, buff;
  logic [LEN_W-1:0] cnt;
  logic fill, fill_start, unused;
`ifdef BUS_DMA_FILL_EN
  assign fill_start = fill_i;
  assign unused = ^{src_i[1:0], dst_i[1:0]};
`else
  assign fill_start = 1'b0;
  assign unused = ^{src_i[1:0], dst_i[1:0], fill_i};
`endif
  // state register
  always_ff @(posedge clk)
    state <= !rst_ni ? IDLE : next;
  // next-state: word loop RD -> RDCAP -> WR, or WR alone when filling
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start_i) next = (len_i == '0) ? FIN : fill_start ? WR : RD;
      RD:      if (ack_i) next = RDCAP;
      RDCAP:   next = WR;
      WR:      if (ack_i) next = (cnt == LEN_W'(1)) ? FIN : fill ? WR : RD;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end
  // bus outputs are pure state decodes, so they stay frozen through wait states
  always_comb begin
    stb_o  = state == RD || state == WR;
    we_o   = state == WR;
    adr_o  = state == RD ? src : state == WR ? dst : '0;
    sel_o  = (state == RD || state == WR) ? 4'hF : 4'h0;
    dat_o  = state == WR ? buff : '0;
    busy_o = state != IDLE;
    done_o = state == FIN;
  end
  // address, count and data buffer; the fill pattern is preloaded into the buffer at start
  always_ff @(posedge clk)
    if (!rst_ni) begin
      src  <= '0;
      dst  <= '0;
      cnt  <= '0;
      fill <= 1'b0;
      buff <= '0;
    end else if (state == IDLE && start_i) begin
      src  <= {src_i[31:2], 2'b00};
      dst  <= {dst_i[31:2], 2'b00};
      cnt  <= len_i;
      fill <= fill_start;
      buff <= fill_data_i;
    end else if (state == RDCAP) begin
      buff <= dat_i;
    end else if (state == WR && ack_i) begin
      src <= src + 32'd4;
      dst <= dst + 32'd4;
      cnt <= cnt - LEN_W'(1);
    end
endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: directed checks of bus_dma against a wait-state responder and bus monitor
module tb_bus_dma;
  logic clk = 0, rst_ni = 0, start = 0, fill = 0, stb, we, busy, done, ack;
  logic [31:0] src = 0, dst = 0, pat = 0, adr, dat_w, dat_r = 0;
  logic [15:0] len = 0;
  logic [3:0] sel;
  int n_chk = 0, n_fail = 0, waits = 0, wcnt = 0;
  int nbusy = 0, ndone = 0, nrd = 0, nunst = 0, nsel = 0;
  logic hold = 0;
  logic [64:0] hold_v = 0;
  logic [31:0] wa[$], wd[$];
  bus_dma #(.LEN_W(16)) dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start), .src_i(src), .dst_i(dst),
    .len_i(len), .fill_i(fill), .fill_data_i(pat), .busy_o(busy), .done_o(done),
    .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel), .dat_o(dat_w),
    .dat_i(dat_r), .ack_i(ack)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a * 3 + 32'h1234_5678;
  endfunction
  assign ack = stb && (wcnt == waits);
  always @(posedge clk) begin
    wcnt <= (stb && !ack) ? wcnt + 1 : 0;
    if (stb && ack && !we) dat_r <= f(adr);
  end
  always @(negedge clk) if (rst_ni) begin
    if (busy) nbusy++;
    if (done) ndone++;
    if (stb && ack) begin
      if (we) begin
        wa.push_back(adr);
        wd.push_back(dat_w);
      end else nrd++;
    end
    if (hold && stb && {adr, we, dat_w} != hold_v) nunst++;
    hold = stb && !ack;
    hold_v = {adr, we, dat_w};
    if (sel != (stb ? 4'hF : 4'h0)) nsel++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input logic fl);
    @(negedge clk);
    nbusy = 0; ndone = 0; nrd = 0; nunst = 0; hold = 0;
    wa.delete(); wd.delete();
    src = s; dst = d; len = l; fill = fl; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done();
    int i;
    for (i = 0; i < 400 && !done; i++) @(negedge clk);
    if (i == 400) check("timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
    check({tag, "_nwr"}, wa.size(), n);
    check({tag, "_nrd"}, nrd, n);
    for (int k = 0; k < n && k < wa.size(); k++) begin
      check({tag, "_adr"}, wa[k], d + 32'(4 * k));
      check({tag, "_dat"}, wd[k], f(s + 32'(4 * k)));
    end
  endtask
  initial begin
    pat = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst_ctl", {busy, done, stb, we, sel}, 0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat_w, 0);
    rst_ni = 1;
    go(32'h0, 32'h100, 4, 0);
    wait_done();
    check_copy("copy", 32'h0, 32'h100, 4);
    check("copy_done", ndone, 1);
    check("copy_busy", nbusy, 13);
    check("copy_xfer", nbusy - ndone, 12);
    go(32'h0, 32'h0, 0, 0);
    wait_done();
    check("len0_stb", wa.size() + nrd, 0);
    check("len0_busy", nbusy, 1);
    check("len0_done", ndone, 1);
    waits = 3;
    go(32'h203, 32'h302, 2, 0);
    @(negedge clk);
    start = 1; len = 7;
    @(negedge clk);
    start = 0;
    wait_done();
    check_copy("wait", 32'h200, 32'h300, 2);
    check("wait_stable", nunst, 0);
    check("wait_busy", nbusy, 19);
    waits = 0;
    go(32'h40, 32'hFFFF_FFFC, 2, 0);
    wait_done();
    check_copy("wrap", 32'h40, 32'hFFFF_FFFC, 2);
    check("wrap_adr1", wa.size() > 1 ? wa[1] : 32'hX, 32'h0);
    go(32'h400, 32'h800, 8, 0);
    for (int i = 0; i < 100 && !(stb && we && adr == 32'h804); i++) @(negedge clk);
    check("rst_reach", {stb, we, adr}, {2'b11, 32'h804});
    rst_ni = 0;
    @(negedge clk);
    check("midrst_stb", stb, 0);
    check("midrst_busy", busy, 0);
    rst_ni = 1;
    ndone = 0;
    repeat (5) @(negedge clk);
    check("midrst_done", ndone, 0);
    go(32'h500, 32'h600, 1, 0);
    wait_done();
    check_copy("restart", 32'h500, 32'h600, 1);
    check("restart_done", ndone, 1);
    go(32'h900, 32'hA00, 3, 1);
    wait_done();
`ifdef BUS_DMA_FILL_EN
    check("fill_nwr", wa.size(), 3);
    check("fill_nrd", nrd, 0);
    check("fill_busy", nbusy, 4);
    for (int k = 0; k < wa.size(); k++) begin
      check("fill_adr", wa[k], 32'hA00 + 32'(4 * k));
      check("fill_dat", wd[k], 32'hDEAD_BEEF);
    end
`else
    check_copy("nofill", 32'h900, 32'hA00, 3);
    check("nofill_busy", nbusy, 10);
`endif
    check("sel", nsel, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
